// File: rtl/mem_stage_wb.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_wb
//  Purpose  : MIPS memory stage fused with the MEM/WB pipeline register.
//             Word loads/stores against an internal data memory, registered
//             results toward write-back and a pre-selected write-back value
//             for the WB stage and the forwarding unit.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH          number of 32-bit words in the data memory (power of two)
//    BASE_ADDR      byte address mapped to word 0
//  Ports
//    clk            pipeline clock, rising edge
//    rst            asynchronous active-low reset
//    freeze         pipeline hold (no store, all registers hold)
//    WB_en_in       write-back enable from EX/MEM
//    MEM_R_EN_in    load request
//    MEM_W_EN_in    store request
//    ALU_result_in  effective byte address / ALU result
//    ST_val_in      store data
//    Dest_in        destination register number
//    WB_en          registered write-back enable
//    MEM_R_EN       registered load flag
//    ALU_result     registered ALU result
//    Mem_read_value registered load data
//    WB_value       registered write-back data (load data or ALU result)
//    Dest           registered destination
//    addr_err       registered bad-address flag of the captured memory op
//    store_count    committed stores since reset, wraps at 2^16
// ============================================================================
module mem_stage_wb #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        freeze,
    input  wire logic        WB_en_in,
    input  wire logic        MEM_R_EN_in,
    input  wire logic        MEM_W_EN_in,
    input  wire logic [31:0] ALU_result_in,
    input  wire logic [31:0] ST_val_in,
    input  wire logic [4:0]  Dest_in,
    output logic             WB_en,
    output logic             MEM_R_EN,
    output logic [31:0]      ALU_result,
    output logic [31:0]      Mem_read_value,
    output logic [31:0]      WB_value,
    output logic [4:0]       Dest,
    output logic             addr_err,
    output logic [15:0]      store_count
);

    localparam int          c_AW    = $clog2(DEPTH);
    // Computed in 33 bits so a window ending at 2^32 does not wrap to 0.
    localparam logic [32:0] c_LOW   = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic            w_in_range;
    logic            w_aligned;
    logic            w_ok;
    logic [c_AW+1:0] w_offset;
    logic [c_AW-1:0] w_index;
    logic [31:0]     w_rdata;
    logic            w_store;
    logic            w_mem_op;

    always_comb begin
        w_in_range = ({1'b0, ALU_result_in} >= c_LOW) &&
                     ({1'b0, ALU_result_in} <  c_LIMIT);
        w_aligned  = (ALU_result_in[1:0] == 2'b00);
        w_ok       = w_in_range && w_aligned;
        // Only the low bits of the offset matter once the range check
        // passes, so the subtraction is done at index width plus byte bits.
        w_offset   = ALU_result_in[c_AW+1:0] - BASE_ADDR[c_AW+1:0];
        w_index    = w_offset[c_AW+1:2];
        w_mem_op   = MEM_R_EN_in || MEM_W_EN_in;
        w_store    = MEM_W_EN_in && w_ok && !freeze;
    end

    // ------------------------------------------------------------------
    // Data memory: cleared by reset, written on a committed store.
    // The read is asynchronous and sampled before the write takes effect,
    // which gives read-before-write for a simultaneous load and store.
    // ------------------------------------------------------------------
    logic [31:0] mem_q [DEPTH];

    assign w_rdata = mem_q[w_index];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (w_store) begin
            mem_q[w_index] <= ST_val_in;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register next-state
    // ------------------------------------------------------------------
    logic        wb_en_q,       wb_en_d;
    logic        mem_r_en_q,    mem_r_en_d;
    logic [31:0] alu_result_q,  alu_result_d;
    logic [31:0] rd_value_q,    rd_value_d;
    logic [31:0] wb_value_q,    wb_value_d;
    logic [4:0]  dest_q,        dest_d;
    logic        addr_err_q,    addr_err_d;
    logic [15:0] store_cnt_q,   store_cnt_d;

    logic [31:0] w_load_data;

    always_comb begin
        // Load data is only meaningful for a load to a legal address;
        // everything else (bad loads, stores, non-memory ops) captures 0.
        w_load_data = (MEM_R_EN_in && w_ok) ? w_rdata : 32'd0;

        wb_en_d      = wb_en_q;
        mem_r_en_d   = mem_r_en_q;
        alu_result_d = alu_result_q;
        rd_value_d   = rd_value_q;
        wb_value_d   = wb_value_q;
        dest_d       = dest_q;
        addr_err_d   = addr_err_q;
        store_cnt_d  = store_cnt_q;

        if (!freeze) begin
            wb_en_d      = WB_en_in;
            mem_r_en_d   = MEM_R_EN_in;
            alu_result_d = ALU_result_in;
            rd_value_d   = w_load_data;
            wb_value_d   = MEM_R_EN_in ? w_load_data : ALU_result_in;
            dest_d       = Dest_in;
            addr_err_d   = w_mem_op && !w_ok;
        end

        if (w_store) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            alu_result_q <= 32'd0;
            rd_value_q   <= 32'd0;
            wb_value_q   <= 32'd0;
            dest_q       <= 5'd0;
            addr_err_q   <= 1'b0;
            store_cnt_q  <= 16'd0;
        end else begin
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            alu_result_q <= alu_result_d;
            rd_value_q   <= rd_value_d;
            wb_value_q   <= wb_value_d;
            dest_q       <= dest_d;
            addr_err_q   <= addr_err_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    assign WB_en          = wb_en_q;
    assign MEM_R_EN       = mem_r_en_q;
    assign ALU_result     = alu_result_q;
    assign Mem_read_value = rd_value_q;
    assign WB_value       = wb_value_q;
    assign Dest           = dest_q;
    assign addr_err       = addr_err_q;
    assign store_count    = store_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_wb
//  Purpose  : Self-checking bench for mem_stage_wb. Directed stimulus pushes
//             hand-computed expectations into a scoreboard queue; a monitor
//             pops and compares on each falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_wb;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        WB_en_in;
    logic        MEM_R_EN_in;
    logic        MEM_W_EN_in;
    logic [31:0] ALU_result_in;
    logic [31:0] ST_val_in;
    logic [4:0]  Dest_in;
    logic        WB_en;
    logic        MEM_R_EN;
    logic [31:0] ALU_result;
    logic [31:0] Mem_read_value;
    logic [31:0] WB_value;
    logic [4:0]  Dest;
    logic        addr_err;
    logic [15:0] store_count;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] wbv;
        logic [4:0]  dest;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    mem_stage_wb #(.DEPTH(64), .BASE_ADDR(32'd1024)) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .WB_en_in       (WB_en_in),
        .MEM_R_EN_in    (MEM_R_EN_in),
        .MEM_W_EN_in    (MEM_W_EN_in),
        .ALU_result_in  (ALU_result_in),
        .ST_val_in      (ST_val_in),
        .Dest_in        (Dest_in),
        .WB_en          (WB_en),
        .MEM_R_EN       (MEM_R_EN),
        .ALU_result     (ALU_result),
        .Mem_read_value (Mem_read_value),
        .WB_value       (WB_value),
        .Dest           (Dest),
        .addr_err       (addr_err),
        .store_count    (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".WB_en"},          {31'd0, WB_en},    {31'd0, e.wb});
        chk({tag, ".MEM_R_EN"},       {31'd0, MEM_R_EN}, {31'd0, e.mr});
        chk({tag, ".ALU_result"},     ALU_result,        e.alu);
        chk({tag, ".Mem_read_value"}, Mem_read_value,    e.rd);
        chk({tag, ".WB_value"},       WB_value,          e.wbv);
        chk({tag, ".Dest"},           {27'd0, Dest},     {27'd0, e.dest});
        chk({tag, ".addr_err"},       {31'd0, addr_err}, {31'd0, e.err});
        chk({tag, ".store_count"},    {16'd0, store_count}, {16'd0, e.cnt});
    endtask

    // Monitor: each expectation describes the outputs after one rising edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk_all("edge", e);
        end
    end

    // One pipeline cycle: drive inputs after a falling edge, then record the
    // expected register contents after the following rising edge.
    task automatic step(input logic we, input logic re, input logic wb,
                        input logic [31:0] alu, input logic [31:0] st,
                        input logic [4:0] dst, input logic frz,
                        input logic e_wb, input logic e_mr, input logic [31:0] e_alu,
                        input logic [31:0] e_rd, input logic [31:0] e_wbv,
                        input logic [4:0] e_dest, input logic e_err,
                        input logic [15:0] e_cnt, input bit check);
        exp_t e;
        @(negedge clk);
        #1;
        MEM_W_EN_in   = we;
        MEM_R_EN_in   = re;
        WB_en_in      = wb;
        ALU_result_in = alu;
        ST_val_in     = st;
        Dest_in       = dst;
        freeze        = frz;
        @(posedge clk);
        e.wb = e_wb; e.mr = e_mr; e.alu = e_alu; e.rd = e_rd;
        e.wbv = e_wbv; e.dest = e_dest; e.err = e_err; e.cnt = e_cnt;
        if (check) sb.push_back(e);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #1;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        exp_t z;
        z.wb = 0; z.mr = 0; z.alu = 0; z.rd = 0; z.wbv = 0; z.dest = 0; z.err = 0; z.cnt = 0;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0; freeze = 1'b0; WB_en_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
        ALU_result_in = 32'd0; ST_val_in = 32'd0; Dest_in = 5'd0;

        // Reset state
        #23;
        chk_all("reset", z);
        @(negedge clk);
        rst = 1'b1;

        //    we re wb alu           st            dst frz | wb mr alu           rd            wbv           dst err cnt
        step(1, 0, 0, 32'd1028,     32'hDEADBEEF, 0, 0,     0, 0, 32'd1028,     32'h0,        32'd1028,     0, 0, 1, 1);
        step(0, 1, 1, 32'd1028,     32'h0,        3, 0,     1, 1, 32'd1028,     32'hDEADBEEF, 32'hDEADBEEF, 3, 0, 1, 1);
        // Last legal word, then out-of-range / misaligned stores
        step(1, 0, 0, 32'd1276,     32'h11112222, 0, 0,     0, 0, 32'd1276,     32'h0,        32'd1276,     0, 0, 2, 1);
        step(0, 1, 1, 32'd1276,     32'h0,        4, 0,     1, 1, 32'd1276,     32'h11112222, 32'h11112222, 4, 0, 2, 1);
        step(1, 0, 0, 32'd1280,     32'h99,       0, 0,     0, 0, 32'd1280,     32'h0,        32'd1280,     0, 1, 2, 1);
        step(1, 0, 0, 32'd1020,     32'h98,       0, 0,     0, 0, 32'd1020,     32'h0,        32'd1020,     0, 1, 2, 1);
        step(1, 0, 0, 32'd1026,     32'h97,       0, 0,     0, 0, 32'd1026,     32'h0,        32'd1026,     0, 1, 2, 1);
        step(0, 1, 1, 32'd1280,     32'h0,        5, 0,     1, 1, 32'd1280,     32'h0,        32'h0,        5, 1, 2, 1);
        // Neighbours of the dropped stores were not disturbed
        step(0, 1, 1, 32'd1024,     32'h0,        6, 0,     1, 1, 32'd1024,     32'h0,        32'h0,        6, 0, 2, 1);
        // Non-memory op with an address outside the window: no error
        step(0, 0, 1, 32'h12345678, 32'h0,        7, 0,     1, 0, 32'h12345678, 32'h0,        32'h12345678, 7, 0, 2, 1);
        // Freeze with a pending store: everything holds
        step(1, 0, 0, 32'd1032,     32'h55,       0, 1,     1, 0, 32'h12345678, 32'h0,        32'h12345678, 7, 0, 2, 1);
        step(1, 0, 0, 32'd1032,     32'h55,       0, 1,     1, 0, 32'h12345678, 32'h0,        32'h12345678, 7, 0, 2, 1);
        step(0, 1, 1, 32'd1032,     32'h0,        8, 0,     1, 1, 32'd1032,     32'h0,        32'h0,        8, 0, 2, 1);
        step(1, 0, 0, 32'd1032,     32'h55,       0, 0,     0, 0, 32'd1032,     32'h0,        32'd1032,     0, 0, 3, 1);
        step(0, 1, 1, 32'd1032,     32'h0,        8, 0,     1, 1, 32'd1032,     32'h55,       32'h55,       8, 0, 3, 1);
        // Simultaneous read/write: old data returned, new data stored
        step(1, 0, 0, 32'd1036,     32'hA,        0, 0,     0, 0, 32'd1036,     32'h0,        32'd1036,     0, 0, 4, 1);
        step(1, 1, 1, 32'd1036,     32'hB,        9, 0,     1, 1, 32'd1036,     32'hA,        32'hA,        9, 0, 5, 1);
        step(0, 1, 1, 32'd1036,     32'h0,        9, 0,     1, 1, 32'd1036,     32'hB,        32'hB,        9, 0, 5, 1);
        // Hold inputs idle-free so outputs are non-zero before reset
        drain();

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_reset", z);
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, 1, 32'd1036,     32'h0,        2, 0,     1, 1, 32'd1036,     32'h0,        32'h0,        2, 0, 0, 1);
        step(0, 1, 1, 32'd1028,     32'h0,        2, 0,     1, 1, 32'd1028,     32'h0,        32'h0,        2, 0, 0, 1);
        drain();

        // Counter wrap: 65536 valid stores from zero
        for (int i = 0; i < 65536; i++) begin
            logic [31:0] a;
            a = 32'd1024 + 32'(4 * (i % 64));
            step(1, 0, 0, a, 32'(i), 0, 0,
                 0, 0, a, 32'h0, a, 0, 0, 16'(i + 1), (i >= 65534));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
